// File: rtl/mu0_prog_memory.sv
// MU0 program memory: two-port word RAM with a boot loader FSM (LOAD -> RELEASE -> RUN).
// Optional same-cycle write-to-read forwarding is enabled by defining MU0_MEM_WRITE_FORWARD_EN.
module mu0_prog_memory #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic [ADDR_W-1:0] address2,
    output logic [DATA_W-1:0] readdata2,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_rst,
    output logic              load_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] load_ptr_q;
    logic [DATA_W-1:0] readdata_q;
    logic [DATA_W-1:0] readdata2_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              load_ready_s;
    logic              cpu_rst_s;
    logic              load_done_s;
    logic              transfer_s;
    logic              ptr_full_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    // Status outputs decoded from the current state
    always_comb begin
        load_ready_s = 1'b0;
        cpu_rst_s    = 1'b0;
        load_done_s  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                load_ready_s = 1'b1;
                cpu_rst_s    = 1'b1;
            end
            ST_RELEASE: begin
                cpu_rst_s    = 1'b1;
            end
            ST_RUN: begin
                load_done_s  = 1'b1;
            end
            default: begin
                cpu_rst_s    = 1'b1;
            end
        endcase
    end

    assign transfer_s = load_valid & load_ready_s;
    assign ptr_full_s = (load_ptr_q == {ADDR_W{1'b1}});

    // Single memory write port shared by the loader (LOAD) and CPU port A (RUN)
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_LOAD) begin
            mem_we_s    = transfer_s;
            mem_waddr_s = load_ptr_q;
            mem_wdata_s = load_data;
        end else if (state_q == ST_RUN) begin
            mem_we_s    = write;
            mem_waddr_s = address;
            mem_wdata_s = writedata;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Read data selection, with optional bypass of the word being written this cycle
    always_comb begin
        rd_a_s = mem_q[address];
        rd_b_s = mem_q[address2];
`ifdef MU0_MEM_WRITE_FORWARD_EN
        if (mem_we_s && (mem_waddr_s == address)) begin
            rd_a_s = mem_wdata_s;
        end else begin
            rd_a_s = mem_q[address];
        end
        if (mem_we_s && (mem_waddr_s == address2)) begin
            rd_b_s = mem_wdata_s;
        end else begin
            rd_b_s = mem_q[address2];
        end
`else
        if (mem_we_s) begin
            rd_a_s = mem_q[address];
        end else begin
            rd_a_s = mem_q[address];
        end
`endif
    end

    // Memory array write; contents survive rst so a restarted load keeps older words
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Loader FSM, load pointer and registered read ports
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            load_ptr_q  <= {ADDR_W{1'b0}};
            readdata_q  <= {DATA_W{1'b0}};
            readdata2_q <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (transfer_s) begin
                        if (load_last || ptr_full_s) begin
                            state_q <= ST_RELEASE;
                        end
                        if (!ptr_full_s) begin
                            load_ptr_q <= load_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (read) begin
                        readdata_q <= rd_a_s;
                    end
                    readdata2_q <= rd_b_s;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign readdata   = readdata_q;
    assign readdata2  = readdata2_q;
    assign load_ready = load_ready_s;
    assign cpu_rst    = cpu_rst_s;
    assign load_done  = load_done_s;

endmodule

// File: tb/tb_mu0_prog_memory.sv
// Directed self-checking bench for mu0_prog_memory (default ADDR_W=12, DATA_W=16).
// Honours MU0_MEM_WRITE_FORWARD_EN for the read-during-write expectation.
module tb_mu0_prog_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] address;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [11:0] address2;
    logic [15:0] readdata2;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_rst;
    logic        load_done;

    int n_cmp = 0;
    int n_err = 0;

    mu0_prog_memory dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .address2   (address2),
        .readdata2  (readdata2),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 16'h5555;
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic crst, input logic done);
        check_eq({tag, "_ready"}, {15'd0, load_ready}, {15'd0, rdy});
        check_eq({tag, "_cpurst"}, {15'd0, cpu_rst}, {15'd0, crst});
        check_eq({tag, "_done"}, {15'd0, load_done}, {15'd0, done});
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        address    = 12'h000;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 16'h0000;
        address2   = 12'h000;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        load_last  = 1'b0;
        tick();
        rst = 1'b0;
        check_status("rst", 1'b1, 1'b1, 1'b0);
        check_eq("rst_rd", readdata, 16'h0000);
        check_eq("rst_rd2", readdata2, 16'h0000);

        // Fill all 4096 words with A000+i, load_last never set
        for (int i = 0; i < 4096; i++) begin
            if (i == 4095) begin
                write     = 1'b1;
                address   = 12'h005;
                writedata = 16'hBEEF;
            end
            load_word(16'hA000 | 16'(i), 1'b0);
            if (i == 4094) check_status("full_4094", 1'b1, 1'b1, 1'b0);
        end
        check_status("full_rel", 1'b0, 1'b1, 1'b0);
        read    = 1'b1;
        address = 12'h005;
        tick();
        check_status("full_run", 1'b0, 1'b0, 1'b1);
        check_eq("rel_read_ignored", readdata, 16'h0000);
        write    = 1'b0;
        address2 = 12'hFFF;
        tick();
        check_eq("full_mem5", readdata, 16'hA005);
        check_eq("full_memfff", readdata2, 16'hAFFF);
        read    = 1'b0;
        address = 12'h006;
        tick();
        check_eq("rd_hold", readdata, 16'hA005);
        check_eq("rd2_cont", readdata2, 16'hAFFF);

        // Gapped loader, then restart mid-load with a coincident transfer
        pulse_rst();
        check_status("rst2", 1'b1, 1'b1, 1'b0);
        check_eq("rst2_rd", readdata, 16'h0000);
        check_eq("rst2_rd2", readdata2, 16'h0000);
        load_word(16'h1111, 1'b0);
        tick();
        tick();
        load_word(16'h2222, 1'b0);
        check_status("gap_load", 1'b1, 1'b1, 1'b0);
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        tick();
        rst        = 1'b0;
        load_valid = 1'b0;
        load_word(16'h9999, 1'b1);
        check_status("restart_rel", 1'b0, 1'b1, 1'b0);
        tick();
        check_status("restart_run", 1'b0, 1'b0, 1'b1);
        read     = 1'b1;
        address  = 12'h000;
        address2 = 12'h001;
        tick();
        check_eq("restart_mem0", readdata, 16'h9999);
        check_eq("retain_mem1", readdata2, 16'h2222);
        address  = 12'h002;
        address2 = 12'h003;
        tick();
        check_eq("discard_mem2", readdata, 16'hA002);
        check_eq("untouched_mem3", readdata2, 16'hA003);
        read = 1'b0;

        // Short program load with load_last on the third word
        pulse_rst();
        load_word(16'h0005, 1'b0);
        load_word(16'h1010, 1'b0);
        check_status("prog_2", 1'b1, 1'b1, 1'b0);
        load_word(16'h7000, 1'b1);
        check_status("prog_rel", 1'b0, 1'b1, 1'b0);
        tick();
        check_status("prog_run", 1'b0, 1'b0, 1'b1);
        read     = 1'b1;
        address  = 12'h001;
        address2 = 12'h002;
        tick();
        check_eq("prog_mem1", readdata, 16'h1010);
        check_eq("prog_mem2", readdata2, 16'h7000);
        address  = 12'h000;
        address2 = 12'h000;
        tick();
        check_eq("prog_mem0_a", readdata, 16'h0005);
        check_eq("prog_mem0_b", readdata2, 16'h0005);

        // Read-during-write on both ports
        read      = 1'b0;
        write     = 1'b1;
        address   = 12'h010;
        writedata = 16'h0003;
        address2  = 12'h020;
        tick();
        read      = 1'b1;
        writedata = 16'h00AB;
        address2  = 12'h010;
        tick();
`ifdef MU0_MEM_WRITE_FORWARD_EN
        check_eq("rdw_a", readdata, 16'h00AB);
        check_eq("rdw_b", readdata2, 16'h00AB);
`else
        check_eq("rdw_a", readdata, 16'h0003);
        check_eq("rdw_b", readdata2, 16'h0003);
`endif
        write = 1'b0;
        tick();
        check_eq("after_wr_a", readdata, 16'h00AB);
        check_eq("after_wr_b", readdata2, 16'h00AB);
        check_status("run_persist", 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mu0_prog_memory.md
MU0_PROG_MEMORY -- requirements
Module: mu0_prog_memory

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width; array depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 16, word width.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 address  input  ADDR_W  port A word address (data/instruction, read/write).
REQ-006 read  input  1  port A read enable.
REQ-007 write  input  1  port A write enable.
REQ-008 writedata  input  DATA_W  port A write data.
REQ-009 readdata  output  DATA_W  port A registered read data.
REQ-010 address2  input  ADDR_W  port B word address (read-only prefetch).
REQ-011 readdata2  output  DATA_W  port B registered read data.
REQ-012 load_valid  input  1  loader word valid.
REQ-013 load_data  input  DATA_W  loader word.
REQ-014 load_last  input  1  final loader word, qualified by load_valid.
REQ-015 load_ready  output  1  loader may transfer; high only in state LOAD.
REQ-016 cpu_rst  output  1  synchronous reset to CPU; high in LOAD and RELEASE.
REQ-017 load_done  output  1  high only in state RUN.

Function
REQ-018 FSM states LOAD, RELEASE, RUN; load_ready, cpu_rst, load_done decoded combinationally from state.
REQ-019 LOAD: transfer = load_valid & load_ready; each transfer writes load_data to mem[load_ptr], load_ptr += 1.
REQ-020 LOAD -> RELEASE on transfer with load_last=1, or on transfer at load_ptr = 2^ADDR_W-1 (full; no wrap, load_last ignored).
REQ-021 load_valid=0 cycles leave load_ptr and memory unchanged.
REQ-022 RELEASE lasts exactly one cycle (cpu_rst=1), then RUN; RUN persists until rst.
REQ-023 In LOAD and RELEASE, port A write is ignored; readdata and readdata2 hold their values.
REQ-024 RUN port A: write=1 -> mem[address] <= writedata at the edge.
REQ-025 RUN port A: read=1 -> readdata <= mem[address] at the edge (1-cycle latency); read=0 -> readdata holds.
REQ-026 RUN port B: readdata2 <= mem[address2] every edge (1-cycle latency, no enable).
REQ-027 read=1 and write=1 same cycle allowed; read-during-write data per REQ-032.
REQ-028 Port B read of the address being written by port A in the same cycle follows REQ-032.
REQ-029 All addresses valid; no out-of-range condition exists.

Reset
REQ-030 rst=1 at an edge: state <= LOAD, load_ptr <= 0, readdata <= 0, readdata2 <= 0; thus load_ready=1, cpu_rst=1, load_done=0 after the edge; a transfer coincident with rst is discarded.
REQ-031 Memory contents are not cleared by rst; rst mid-load restarts loading at address 0, retaining earlier words.

Configuration
REQ-032 MU0_MEM_WRITE_FORWARD_EN defined: a read (port A or B) of the address written that cycle returns writedata; undefined: it returns the pre-write contents.

Verification
REQ-033 After rst, transfer 0x0005, 0x1010, 0x7000 (last on third) -> load_ready low the cycle after third transfer, cpu_rst high exactly one more cycle, then load_done=1; mem[0..2] = 0x0005, 0x1010, 0x7000.
REQ-034 RUN, read=1 address=0x001, address2=0x002 -> next cycle readdata=0x1010, readdata2=0x7000.
REQ-035 RUN, mem[0x010]=0x0003, write=1 read=1 address=0x010 writedata=0x00AB, address2=0x010 -> readdata=readdata2=0x0003 (macro undefined) or 0x00AB (macro defined); following read returns 0x00AB.
REQ-036 Loader with load_valid pattern 1,0,0,1 (words 0x1111, 0x2222) -> mem[0]=0x1111, mem[1]=0x2222, no extra writes; state stays LOAD.
REQ-037 rst asserted after 2 of 4 words -> next transfer 0x9999 lands at address 0; mem[1] retains earlier word.
REQ-038 4096 transfers with load_last=0 -> RELEASE after word 4095, then RUN; RUN write=1 ignored while cpu_rst=1.
